bram_rv_port: RTL and testbench
===============================

Name: bram_rv_port

Overview:
Single-port synchronous block RAM wrapped in valid/ready handshakes for write and read, with per-byte write enables. Used as on-chip instruction/data memory behind the core's memory bus. One shared address bus serves both directions. Reads are registered with one-cycle latency.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words
BE_WIDTH (localparam), DATA_WIDTH/8, number of byte lanes

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  reset, synchronous, active-high
i_addr  in  ADDR_WIDTH  word address, shared by read and write
i_data  in  DATA_WIDTH  write data
i_wr_valid  in  1  write request
o_wr_ready  out  1  write accepted this cycle (combinational)
i_byte_write_enable  in  BE_WIDTH  lane mask; bit k writes bits [8k+7:8k]
o_data  out  DATA_WIDTH  registered read data
o_rd_valid  out  1  o_data valid this cycle
i_rd_ready  in  1  read request / consumer ready

Behaviour:
- Storage: array mem[0..2**ADDR_WIDTH-1] of DATA_WIDTH bits, hierarchically named mem in an inner instance named bram. Not cleared by reset.
- Internal flag reading (1 bit, registered), exposed as o_rd_valid. Reset value 0.
- o_wr_ready = i_wr_valid & ~reading. Purely combinational, no clock needed. Low whenever i_wr_valid is low.
- Write handshake: at the rising edge with i_wr_valid & o_wr_ready, write every lane k with i_byte_write_enable[k]=1: mem[i_addr][8k+7:8k] <= i_data[8k+7:8k]. Disabled lanes keep their old value. All-zero mask makes the handshake complete with no change.
- Write data is visible in mem immediately after the accepting edge.
- Read acceptance: at each rising edge, read_go = i_rd_ready & ~(i_wr_valid & o_wr_ready).
- On read_go: reading <= 1 and o_data <= mem[i_addr], using pre-edge contents. Otherwise reading <= 0.
- o_data holds its last value while reading=0.
- Latency is 1 cycle: a request sampled at edge N gives data and o_rd_valid=1 after edge N.
- Continuous i_rd_ready=1 streams one word per cycle from the current i_addr, with o_rd_valid held high.
- Dropping i_rd_ready clears reading at the next edge.
- Simultaneous request with reading=0: the write wins (o_wr_ready=1), the read is not accepted that edge, and reading goes to 0.
- Simultaneous request with reading=1: o_wr_ready=0, so the read proceeds and the write stalls until reading drops.
- Reset (i_rst=1 at an edge): reading <= 0, o_data <= 0, no memory write, no read acceptance. o_wr_ready is forced low for as long as i_rst is high.
- Reset mid-stream: o_rd_valid is 0 after the reset edge, and memory contents are preserved.
- Address wraps naturally within ADDR_WIDTH bits; no out-of-range handling.

Optional Feature:
BRAM_RV_ZERO_INIT_EN
- Defined: mem is initialised to all zeros at time 0 (initial block), so reads of unwritten words return 0.
- Undefined: no initialisation; unwritten words read as X in simulation and as the power-on state in hardware.
- Reset behaviour is identical in both builds.

Test Plan:
1. Reset, then i_wr_valid=1, addr=21, data=0xAA, BE=4'b1111 -> o_wr_ready=1 before the edge; after the edge with valid dropped, o_wr_ready=0 and mem[21]=0xAA.
2. i_rd_ready=1, addr=21 with reading=0 -> after 1 edge reading=1, o_rd_valid=1, o_data=0xAA. Drop rd_ready -> reading=0 after the next edge. Rewrite 0xAB and reread -> 0xAB.
3. Write 21=0xAA, 22=0xBB, 23=0xCC; read each back -> 0xAA, 0xBB, 0xCC. Write 23=0x2211FFEE -> reads 0x2211FFEE, and 22 still reads 0xBB.
4. mem[5]=0xFFFFFFFF; write 0x12345678 with BE=4'b0101 -> mem[5]=0xFF34FF78.
5. Hold rd_ready=1 while stepping addr 21, 22, 23 -> o_data follows one cycle behind, o_rd_valid stays 1. Raise wr_valid during the stream -> o_wr_ready=0 and no write occurs.
6. wr_valid and rd_ready both high with reading=0 -> write performed, reading=0 after the edge. Assert i_rst during a stream -> o_rd_valid=0, o_data=0, memory intact.

Source files
------------

// File: rtl/bram_rv_port.sv
// bram_rv_port: valid/ready single-port block RAM with byte-lane writes and 1-cycle registered reads (optional BRAM_RV_ZERO_INIT_EN zero-fills memory at time 0)
module bram_rv_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [BE_WIDTH-1:0]   i_we,
   input  logic                  i_re,
   output logic [DATA_WIDTH-1:0] o_rdata
);
   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] rdata_q;
`ifdef BRAM_RV_ZERO_INIT_EN
   initial for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = '0;
`else
`endif
   // Byte-lane writes; the array is never touched by reset so contents survive it.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < BE_WIDTH; k++)
         if (i_we[k]) mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
   end
   // Registered read port using pre-edge contents; holds its value when no read is accepted.
   always_ff @(posedge i_clk) begin
      if (i_rst) rdata_q <= '0;
      else if (i_re) rdata_q <= mem[i_addr];
   end
   assign o_rdata = rdata_q;
endmodule

module bram_rv_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [ADDR_WIDTH-1:0]      i_addr,
   input  logic [DATA_WIDTH-1:0]      i_data,
   input  logic                       i_wr_valid,
   output logic                       o_wr_ready,
   input  logic [DATA_WIDTH/8-1:0]    i_byte_write_enable,
   output logic [DATA_WIDTH-1:0]      o_data,
   output logic                       o_rd_valid,
   input  logic                       i_rd_ready
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;
   logic                reading_q, reading_d, read_go;
   logic [BE_WIDTH-1:0] we;
   // Writes win only while no read is in flight; reads yield to an accepted write.
   always_comb begin
      o_wr_ready = i_wr_valid & ~reading_q & ~i_rst;
      read_go    = i_rd_ready & ~(i_wr_valid & o_wr_ready) & ~i_rst;
      reading_d  = read_go;
      we         = o_wr_ready ? i_byte_write_enable : '0;
   end
   // Read-in-flight flag, which doubles as the output valid.
   always_ff @(posedge i_clk) begin
      if (i_rst) reading_q <= 1'b0;
      else reading_q <= reading_d;
   end
   assign o_rd_valid = reading_q;
   bram_rv_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
   ) bram (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_addr  (i_addr),
      .i_wdata (i_data),
      .i_we    (we),
      .i_re    (read_go),
      .o_rdata (o_data)
   );
endmodule

// File: tb/tb_bram_rv_port.sv
// tb_bram_rv_port: directed self-checking bench for bram_rv_port
module tb_bram_rv_port;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  addr;
   logic [31:0] data;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        rd_valid;
   logic        rd_ready;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   bram_rv_port dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_addr              (addr),
      .i_data              (data),
      .i_wr_valid          (wr_valid),
      .o_wr_ready          (wr_ready),
      .i_byte_write_enable (be),
      .o_data              (rdata),
      .o_rd_valid          (rd_valid),
      .i_rd_ready          (rd_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a; data = d; be = m; wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      #1;
   endtask

   task automatic rd(input logic [9:0] a, output logic [31:0] d);
      addr = a; rd_ready = 1'b1;
      step();
      d = rdata;
      rd_ready = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1; wr_valid = 1'b1; rd_ready = 1'b0; addr = 10'd21; data = 32'hAA; be = 4'hF;
      step(); step();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
      n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", rdata); end
      n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
      wr_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL idle_wr_ready got=%b exp=0", wr_ready); end
      wr_valid = 1'b1;
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_pre got=%b exp=1", wr_ready); end
      step();
      wr_valid = 1'b0;
      #1;
      n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_post got=%b exp=0", wr_ready); end
      rd(10'd21, r);
      n_cmp++; if (r !== 32'hAA) begin n_err++; $display("FAIL first_write got=%h exp=000000aa", r); end
   endtask

   task automatic test_read();
      logic [31:0] r;
      addr = 10'd21; rd_ready = 1'b1;
      step();
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid got=%b exp=1", rd_valid); end
      n_cmp++; if (rdata !== 32'hAA) begin n_err++; $display("FAIL rd_data got=%h exp=000000aa", rdata); end
      rd_ready = 1'b0;
      step();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_drop got=%b exp=0", rd_valid); end
      n_cmp++; if (rdata !== 32'hAA) begin n_err++; $display("FAIL rd_hold got=%h exp=000000aa", rdata); end
      wr(10'd21, 32'hAB, 4'hF);
      rd(10'd21, r);
      n_cmp++; if (r !== 32'hAB) begin n_err++; $display("FAIL rewrite got=%h exp=000000ab", r); end
   endtask

   task automatic test_multi_word();
      logic [31:0] r;
      wr(10'd21, 32'hAA, 4'hF);
      wr(10'd22, 32'hBB, 4'hF);
      wr(10'd23, 32'hCC, 4'hF);
      rd(10'd21, r);
      n_cmp++; if (r !== 32'hAA) begin n_err++; $display("FAIL word21 got=%h exp=000000aa", r); end
      rd(10'd22, r);
      n_cmp++; if (r !== 32'hBB) begin n_err++; $display("FAIL word22 got=%h exp=000000bb", r); end
      rd(10'd23, r);
      n_cmp++; if (r !== 32'hCC) begin n_err++; $display("FAIL word23 got=%h exp=000000cc", r); end
      wr(10'd23, 32'h2211FFEE, 4'hF);
      rd(10'd23, r);
      n_cmp++; if (r !== 32'h2211FFEE) begin n_err++; $display("FAIL word23_new got=%h exp=2211ffee", r); end
      rd(10'd22, r);
      n_cmp++; if (r !== 32'hBB) begin n_err++; $display("FAIL word22_kept got=%h exp=000000bb", r); end
   endtask

   task automatic test_byte_enable();
      logic [31:0] r;
      wr(10'd5, 32'hFFFFFFFF, 4'hF);
      wr(10'd5, 32'h12345678, 4'b0101);
      rd(10'd5, r);
      n_cmp++; if (r !== 32'hFF34FF78) begin n_err++; $display("FAIL be_0101 got=%h exp=ff34ff78", r); end
      wr(10'd5, 32'h0, 4'b1000);
      rd(10'd5, r);
      n_cmp++; if (r !== 32'h0034FF78) begin n_err++; $display("FAIL be_1000 got=%h exp=0034ff78", r); end
      wr(10'd5, 32'hDEADBEEF, 4'b0000);
      rd(10'd5, r);
      n_cmp++; if (r !== 32'h0034FF78) begin n_err++; $display("FAIL be_none got=%h exp=0034ff78", r); end
   endtask

   task automatic test_stream();
      logic [31:0] r;
      addr = 10'd21; rd_ready = 1'b1;
      step();
      n_cmp++; if (rdata !== 32'hAA || rd_valid !== 1'b1) begin n_err++; $display("FAIL stream21 got=%h/%b exp=000000aa/1", rdata, rd_valid); end
      addr = 10'd22;
      step();
      n_cmp++; if (rdata !== 32'hBB || rd_valid !== 1'b1) begin n_err++; $display("FAIL stream22 got=%h/%b exp=000000bb/1", rdata, rd_valid); end
      addr = 10'd23; wr_valid = 1'b1; data = 32'h55555555; be = 4'hF;
      #1;
      n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL stream_wr_block got=%b exp=0", wr_ready); end
      step();
      n_cmp++; if (rdata !== 32'h2211FFEE || rd_valid !== 1'b1) begin n_err++; $display("FAIL stream23 got=%h/%b exp=2211ffee/1", rdata, rd_valid); end
      wr_valid = 1'b0; rd_ready = 1'b0;
      step();
      rd(10'd23, r);
      n_cmp++; if (r !== 32'h2211FFEE) begin n_err++; $display("FAIL stall_no_write got=%h exp=2211ffee", r); end
   endtask

   task automatic test_collision_and_reset();
      logic [31:0] r;
      addr = 10'd30; data = 32'h600DF00D; be = 4'hF; wr_valid = 1'b1; rd_ready = 1'b1;
      #1;
      n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL collide_wr_ready got=%b exp=1", wr_ready); end
      step();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL collide_rd_valid got=%b exp=0", rd_valid); end
      wr_valid = 1'b0; rd_ready = 1'b0;
      step();
      rd(10'd30, r);
      n_cmp++; if (r !== 32'h600DF00D) begin n_err++; $display("FAIL collide_write got=%h exp=600df00d", r); end
      addr = 10'd21; rd_ready = 1'b1;
      step();
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid got=%b exp=1", rd_valid); end
      rst = 1'b1; wr_valid = 1'b1; data = 32'h77777777;
      #1;
      n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
      step();
      n_cmp++; if (rd_valid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL mid_reset got=%h/%b exp=00000000/0", rdata, rd_valid); end
      rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      step();
      rd(10'd21, r);
      n_cmp++; if (r !== 32'hAA) begin n_err++; $display("FAIL mem_kept got=%h exp=000000aa", r); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_multi_word();
      test_byte_enable();
      test_stream();
      test_collision_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
